pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid_if.sv | 34 +++
 rtl/pipe_stage_skid.sv | 153 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Bundle interface for the skid-buffered pipeline stage: an upstream valid/ready
// bundle in and a downstream valid/ready bundle out. The slave modport is the stage's view.
interface pipe_stage_skid_if #(
  parameter int PC_WIDTH      = 12,
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_OPS       = 3,
  parameter int REGADDR_WIDTH = 3,
  parameter int NUM_REGS      = 3,
  parameter int CTRL_WIDTH    = 7
) ();
  logic                              in_valid;
  logic                              in_ready;
  logic [CTRL_WIDTH-1:0]             in_ctrl;
  logic [PC_WIDTH-1:0]               in_pc;
  logic [NUM_OPS*DATA_WIDTH-1:0]     in_ops;
  logic [NUM_REGS*REGADDR_WIDTH-1:0] in_regs;

  logic                              out_valid;
  logic                              out_ready;
  logic [CTRL_WIDTH-1:0]             out_ctrl;
  logic [PC_WIDTH-1:0]               out_pc;
  logic [NUM_OPS*DATA_WIDTH-1:0]     out_ops;
  logic [NUM_REGS*REGADDR_WIDTH-1:0] out_regs;

  modport master (
    output in_valid, in_ctrl, in_pc, in_ops, in_regs, out_ready,
    input  in_ready, out_valid, out_ctrl, out_pc, out_ops, out_regs
  );

  modport slave (
    input  in_valid, in_ctrl, in_pc, in_ops, in_regs, out_ready,
    output in_ready, out_valid, out_ctrl, out_pc, out_ops, out_regs
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) pipeline register with registered in_ready, synchronous
// flush, bubble control masking and saturating stall/flush statistics.
module pipe_stage_skid #(
  parameter int PC_WIDTH      = 12,
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_OPS       = 3,
  parameter int REGADDR_WIDTH = 3,
  parameter int NUM_REGS      = 3,
  parameter int CTRL_WIDTH    = 7,
  parameter int CNT_WIDTH     = 8,
  parameter bit FLUSH_ZERO    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipe_stage_skid_if.slave     bus,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef struct packed {
    logic [CTRL_WIDTH-1:0]             ctrl;
    logic [PC_WIDTH-1:0]               pc;
    logic [NUM_OPS*DATA_WIDTH-1:0]     ops;
    logic [NUM_REGS*REGADDR_WIDTH-1:0] regs;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_in_ready;
  entry_t               r_main;
  entry_t               r_skid;
  entry_t               w_in_entry;
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic [CNT_WIDTH-1:0] r_flush_count;

  logic w_accept;
  logic w_consume;
  logic w_out_valid;
  logic w_load_main;
  logic w_load_skid;
  logic w_main_from_skid;
  logic w_clear;

  assign w_in_entry = '{ctrl: bus.in_ctrl, pc: bus.in_pc, ops: bus.in_ops, regs: bus.in_regs};

  assign w_out_valid = (r_state != EMPTY);
  assign w_accept    = bus.in_valid & r_in_ready;
  assign w_consume   = w_out_valid & bus.out_ready;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    w_clear          = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_load_main = 1'b1;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_accept && w_consume) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_load_skid = 1'b1;
          w_state_nxt = FULL;
        end else if (w_consume) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a consume can move the state.
        if (w_consume) begin
          w_main_from_skid = 1'b1;
          w_state_nxt      = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) begin
      w_state_nxt      = EMPTY;
      w_load_main      = 1'b0;
      w_load_skid      = 1'b0;
      w_main_from_skid = 1'b0;
      w_clear          = FLUSH_ZERO;
    end
  end

  // NOTE: the data entries are reset too, because the outputs must read zero during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (w_clear) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main) begin
        r_main <= w_in_entry;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_entry;
      end
    end
  end

  // Statistics keep counting through flush; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_out_valid && !bus.out_ready && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end
      if (flush && (r_state != EMPTY) && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + CNT_ONE;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_ctrl  = w_out_valid ? r_main.ctrl : '0;
  assign bus.out_pc    = r_main.pc;
  assign bus.out_ops   = r_main.ops;
  assign bus.out_regs  = r_main.regs;
  assign stall_count   = r_stall_count;
  assign flush_count   = r_flush_count;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: default build (A) plus a FLUSH_ZERO=0, CNT_WIDTH=2 build (B).
module tb_pipe_stage_skid;

  logic clk;
  logic reset;
  logic flush_a;
  logic flush_b;
  logic [7:0] stall_a, flush_cnt_a;
  logic [1:0] stall_b, flush_cnt_b;
  int total = 0;
  int bad   = 0;

  pipe_stage_skid_if ifa ();
  pipe_stage_skid_if ifb ();

  pipe_stage_skid dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .bus(ifa),
    .stall_count(stall_a), .flush_count(flush_cnt_a)
  );

  pipe_stage_skid #(.CNT_WIDTH(2), .FLUSH_ZERO(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .bus(ifb),
    .stall_count(stall_b), .flush_count(flush_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [11:0] pc, input logic [6:0] ctrl);
    ifa.in_valid = 1'b1;
    ifa.in_pc    = pc;
    ifa.in_ctrl  = ctrl;
    ifa.in_ops   = {4'hC, pc, 4'hB, pc, 4'hA, pc};
    ifa.in_regs  = 9'b011_010_001;
  endtask

  task automatic push_b(input logic [11:0] pc, input logic [6:0] ctrl);
    ifb.in_valid = 1'b1;
    ifb.in_pc    = pc;
    ifb.in_ctrl  = ctrl;
    ifb.in_ops   = {4'hC, pc, 4'hB, pc, 4'hA, pc};
    ifb.in_regs  = 9'b011_010_001;
  endtask

  initial begin
    reset = 1'b1;
    flush_a = 1'b0;
    flush_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_pc = '0; ifa.in_ctrl = '0; ifa.in_ops = '0; ifa.in_regs = '0;
    ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_pc = '0; ifb.in_ctrl = '0; ifb.in_ops = '0; ifb.in_regs = '0;
    ifb.out_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", 64'(ifa.in_ready), 64'h1);
    check("rst_out_valid", 64'(ifa.out_valid), 64'h0);
    check("rst_out_pc", 64'(ifa.out_pc), 64'h0);
    check("rst_out_ctrl", 64'(ifa.out_ctrl), 64'h0);
    check("rst_stall", 64'(stall_a), 64'h0);
    check("rst_flush_cnt", 64'(flush_cnt_a), 64'h0);
    #3 reset = 1'b0;

    // Back-to-back stream with out_ready=1
    push_a(12'h010, 7'h55);
    tick();
    check("s0_valid", 64'(ifa.out_valid), 64'h1);
    check("s0_pc", 64'(ifa.out_pc), 64'h010);
    check("s0_ctrl", 64'(ifa.out_ctrl), 64'h55);
    check("s0_in_ready", 64'(ifa.in_ready), 64'h1);
    push_a(12'h011, 7'h2A);
    tick();
    check("s1_pc", 64'(ifa.out_pc), 64'h011);
    check("s1_ctrl", 64'(ifa.out_ctrl), 64'h2A);
    check("s1_in_ready", 64'(ifa.in_ready), 64'h1);
    push_a(12'h012, 7'h7F);
    tick();
    check("s2_pc", 64'(ifa.out_pc), 64'h012);
    check("s2_ops", 64'(ifa.out_ops), 64'hC012_B012_A012);
    check("s2_regs", 64'(ifa.out_regs), 64'h0D1);
    ifa.in_valid = 1'b0;
    tick();
    check("s3_valid", 64'(ifa.out_valid), 64'h0);
    check("s3_ctrl_bubble", 64'(ifa.out_ctrl), 64'h0);
    check("s3_stall", 64'(stall_a), 64'h0);

    // Backpressure fills the skid entry
    ifa.out_ready = 1'b0;
    push_a(12'h020, 7'h11);
    tick();
    check("bp0_pc", 64'(ifa.out_pc), 64'h020);
    check("bp0_in_ready", 64'(ifa.in_ready), 64'h1);
    check("bp0_stall", 64'(stall_a), 64'h0);
    push_a(12'h021, 7'h22);
    tick();
    check("bp1_in_ready", 64'(ifa.in_ready), 64'h0);
    check("bp1_pc", 64'(ifa.out_pc), 64'h020);
    check("bp1_stall", 64'(stall_a), 64'h1);
    push_a(12'h0FF, 7'h33);
    tick();
    check("bp2_pc", 64'(ifa.out_pc), 64'h020);
    check("bp2_ctrl", 64'(ifa.out_ctrl), 64'h11);
    check("bp2_stall", 64'(stall_a), 64'h2);
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    tick();
    check("bp3_pc", 64'(ifa.out_pc), 64'h021);
    check("bp3_ctrl", 64'(ifa.out_ctrl), 64'h22);
    check("bp3_in_ready", 64'(ifa.in_ready), 64'h1);
    check("bp3_stall", 64'(stall_a), 64'h2);
    tick();
    check("bp4_valid", 64'(ifa.out_valid), 64'h0);

    // Flush in FULL with a same-cycle offer
    ifa.out_ready = 1'b0;
    push_a(12'h040, 7'h44);
    tick();
    push_a(12'h041, 7'h45);
    tick();
    check("fl0_in_ready", 64'(ifa.in_ready), 64'h0);
    check("fl0_stall", 64'(stall_a), 64'h3);
    flush_a = 1'b1;
    push_a(12'h030, 7'h66);
    tick();
    check("fl1_valid", 64'(ifa.out_valid), 64'h0);
    check("fl1_ctrl", 64'(ifa.out_ctrl), 64'h0);
    check("fl1_pc", 64'(ifa.out_pc), 64'h0);
    check("fl1_ops", 64'(ifa.out_ops), 64'h0);
    check("fl1_in_ready", 64'(ifa.in_ready), 64'h1);
    check("fl1_flush_cnt", 64'(flush_cnt_a), 64'h1);
    check("fl1_stall", 64'(stall_a), 64'h4);
    flush_a = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    tick();
    check("fl2_valid", 64'(ifa.out_valid), 64'h0);
    // Flush in EMPTY does not count
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    check("fl3_flush_cnt", 64'(flush_cnt_a), 64'h1);

    // Asynchronous reset between edges while FULL
    ifa.out_ready = 1'b0;
    push_a(12'h050, 7'h50);
    tick();
    push_a(12'h051, 7'h51);
    tick();
    check("ar0_in_ready", 64'(ifa.in_ready), 64'h0);
    ifa.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("ar1_valid", 64'(ifa.out_valid), 64'h0);
    check("ar1_pc", 64'(ifa.out_pc), 64'h0);
    check("ar1_ctrl", 64'(ifa.out_ctrl), 64'h0);
    check("ar1_ops", 64'(ifa.out_ops), 64'h0);
    check("ar1_in_ready", 64'(ifa.in_ready), 64'h1);
    check("ar1_stall", 64'(stall_a), 64'h0);
    check("ar1_flush_cnt", 64'(flush_cnt_a), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    ifa.out_ready = 1'b1;
    push_a(12'h060, 7'h60);
    tick();
    check("ar2_valid", 64'(ifa.out_valid), 64'h1);
    check("ar2_pc", 64'(ifa.out_pc), 64'h060);
    ifa.in_valid = 1'b0;

    // Build B: flush in ONE holds data fields
    push_b(12'h070, 7'h70);
    tick();
    check("b0_pc", 64'(ifb.out_pc), 64'h070);
    check("b0_valid", 64'(ifb.out_valid), 64'h1);
    ifb.in_valid = 1'b0;
    flush_b = 1'b1;
    tick();
    flush_b = 1'b0;
    check("b1_valid", 64'(ifb.out_valid), 64'h0);
    check("b1_ctrl", 64'(ifb.out_ctrl), 64'h0);
    check("b1_pc_hold", 64'(ifb.out_pc), 64'h070);
    check("b1_flush_cnt", 64'(flush_cnt_b), 64'h1);

    // Build B: 2-bit stall counter saturates
    ifb.out_ready = 1'b0;
    push_b(12'h080, 7'h08);
    tick();
    ifb.in_valid = 1'b0;
    check("b2_pc", 64'(ifb.out_pc), 64'h080);
    check("b2_stall", 64'(stall_b), 64'h0);
    repeat (2) tick();
    check("b3_stall", 64'(stall_b), 64'h2);
    repeat (4) tick();
    check("b4_stall_sat", 64'(stall_b), 64'h3);
    check("b4_pc", 64'(ifb.out_pc), 64'h080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
